// File: rtl/alu_mc_pkg.sv
// Shared ALU operation codes, FSM state encoding and iterative-datapath op selects for alu_mc.
package alu_mc_pkg;

  localparam logic [3:0] FUNC_ADD    = 4'd0;
  localparam logic [3:0] FUNC_SUB    = 4'd1;
  localparam logic [3:0] FUNC_AND    = 4'd2;
  localparam logic [3:0] FUNC_ORR    = 4'd3;
  localparam logic [3:0] FUNC_NOT    = 4'd4;
  localparam logic [3:0] FUNC_TCP    = 4'd5;
  localparam logic [3:0] FUNC_SHL1   = 4'd6;
  localparam logic [3:0] FUNC_SHR1   = 4'd7;
  localparam logic [3:0] FUNC_LHI    = 4'd8;
  localparam logic [3:0] FUNC_PASS_A = 4'd9;
  localparam logic [3:0] FUNC_PASS_B = 4'd10;
  localparam logic [3:0] FUNC_SHLN   = 4'd11;
  localparam logic [3:0] FUNC_SHRN   = 4'd12;
  localparam logic [3:0] FUNC_MUL    = 4'd13;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] SM_SHL = 2'd0;
  localparam logic [1:0] SM_SHR = 2'd1;
  localparam logic [1:0] SM_MUL = 2'd2;

endpackage

// File: rtl/alu_mc_shiftmul.sv
// Iterative datapath: N-bit shifts one bit per cycle, shift-add multiply over WORD_SIZE cycles.
// last_o flags the final step; res_o is the value that step produces. Multiplier only with ALU_MC_MUL_EN.
module alu_mc_shiftmul
  import alu_mc_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int SHAMT_W   = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  output logic                 last_o,
  output logic [WORD_SIZE-1:0] res_o
);
  // One extra counter bit so a count of WORD_SIZE (multiply) fits without wrapping.
  localparam int CNT_W = SHAMT_W + 1;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WORD_SIZE-1:0] sh_q, sh_d;
  logic                 step;

  assign step   = !start_i && (cnt_q != '0);
  assign last_o = (cnt_q == CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    sh_d  = sh_q;
    if (start_i) begin
      op_d  = op_i;
      sh_d  = a_i;
      cnt_d = (op_i == SM_MUL) ? CNT_W'(WORD_SIZE) : {1'b0, b_i[SHAMT_W-1:0]};
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(1);
      sh_d  = (op_q == SM_SHR) ? {sh_q[WORD_SIZE-1], sh_q[WORD_SIZE-1:1]}
                               : {sh_q[WORD_SIZE-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= SM_SHL;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      sh_q  <= sh_d;
    end
  end

`ifdef ALU_MC_MUL_EN
  // sh_q doubles as the left-shifting multiplicand; mpl_q feeds multiplier bits LSB first.
  logic [WORD_SIZE-1:0] prod_q, prod_d, mpl_q, mpl_d;

  always_comb begin
    prod_d = prod_q;
    mpl_d  = mpl_q;
    if (start_i) begin
      prod_d = '0;
      mpl_d  = b_i;
    end else if (step && (op_q == SM_MUL)) begin
      if (mpl_q[0]) prod_d = prod_q + sh_q;
      mpl_d = mpl_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      mpl_q  <= '0;
    end else begin
      prod_q <= prod_d;
      mpl_q  <= mpl_d;
    end
  end

  assign res_o = (op_q == SM_MUL) ? prod_d : sh_d;
`else
  logic unused_b_hi;
  assign unused_b_hi = ^b_i[WORD_SIZE-1:SHAMT_W];
  assign res_o       = sh_d;
`endif

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle ops latency 1, SHLN/SHRN n+1, MUL WORD_SIZE+1.
// Result is held in DONE until out_ready; ALU_MC_MUL_EN enables the multiplier (code 13), else it is illegal.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int SHAMT_W   = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [3:0]           alu_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] c,
  output logic                 zero,
  output logic                 ovf,
  output logic                 err
);
  localparam int MSB = WORD_SIZE - 1;

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] c_q, c_d;
  logic                 zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
  logic [WORD_SIZE-1:0] sum, diff, op_res, sm_res;
  logic                 op_ovf, op_err, op_multi, sm_start, sm_last;
  logic [1:0]           sm_op;
  logic [SHAMT_W-1:0]   shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    op_res   = '0;
    op_ovf   = 1'b0;
    op_err   = 1'b0;
    op_multi = 1'b0;
    sm_op    = SM_SHL;
    case (alu_code)
      FUNC_ADD:    begin
        op_res = sum;
        op_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      FUNC_SUB:    begin
        op_res = diff;
        op_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      FUNC_AND:    op_res = a & b;
      FUNC_ORR:    op_res = a | b;
      FUNC_NOT:    op_res = ~a;
      FUNC_TCP:    op_res = -a;
      FUNC_SHL1:   op_res = {a[MSB-1:0], 1'b0};
      FUNC_SHR1:   op_res = {a[MSB], a[MSB:1]};
      FUNC_LHI:    op_res = b << 8;
      FUNC_PASS_A: op_res = a;
      FUNC_PASS_B: op_res = b;
      // A zero shift amount completes immediately with c=a.
      FUNC_SHLN:   begin
        op_res   = a;
        op_multi = (shamt != '0);
        sm_op    = SM_SHL;
      end
      FUNC_SHRN:   begin
        op_res   = a;
        op_multi = (shamt != '0);
        sm_op    = SM_SHR;
      end
`ifdef ALU_MC_MUL_EN
      FUNC_MUL:    begin
        op_multi = 1'b1;
        sm_op    = SM_MUL;
      end
`endif
      default:     op_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    sm_start = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        if (op_multi) begin
          state_d  = ST_EXEC;
          sm_start = 1'b1;
        end else begin
          state_d = ST_DONE;
          c_d     = op_res;
          zero_d  = (op_res == '0);
          ovf_d   = op_ovf;
          err_d   = op_err;
        end
      end
      ST_EXEC: if (sm_last) begin
        state_d = ST_DONE;
        c_d     = sm_res;
        zero_d  = (sm_res == '0);
        ovf_d   = 1'b0;
        err_d   = 1'b0;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  alu_mc_shiftmul #(
    .WORD_SIZE (WORD_SIZE),
    .SHAMT_W   (SHAMT_W)
  ) u_shiftmul (
    .clk     (clk),
    .reset   (reset),
    .start_i (sm_start),
    .op_i    (sm_op),
    .a_i     (a),
    .b_i     (b),
    .last_o  (sm_last),
    .res_o   (sm_res)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign c         = c_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver pushes reference-model results, monitor pops and compares on out_valid.
module tb_alu_mc;

  typedef struct {
    logic [15:0] c;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  alu_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] c;
  logic        zero, ovf, err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_req = 0;
  exp_t expq[$];

  alu_mc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_code  (alu_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .zero      (zero),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference behaviour from the operation definitions, using wide signed/unsigned integer arithmetic.
  function automatic exp_t model(input logic [3:0] code, input logic [15:0] ia, input logic [15:0] ib);
    exp_t   e;
    longint sa, sb, ua, ub, r;
    int     n;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    ua = longint'(ia);
    ub = longint'(ib);
    n  = int'(ib % 16);
    r  = 0;
    e.ovf = 1'b0;
    e.err = 1'b0;
    e.lat = 1;
    e.acc_cyc = 0;
    case (code)
      4'd0:  begin r = sa + sb; e.ovf = (r > 32767 || r < -32768); end
      4'd1:  begin r = sa - sb; e.ovf = (r > 32767 || r < -32768); end
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = 65535 - ua;
      4'd5:  r = -sa;
      4'd6:  r = ua * 2;
      4'd7:  r = sa >>> 1;
      4'd8:  r = ub * 256;
      4'd9:  r = ua;
      4'd10: r = ub;
      4'd11: begin r = ua * (longint'(1) << n); e.lat = (n == 0) ? 1 : n + 1; end
      4'd12: begin r = sa >>> n; e.lat = (n == 0) ? 1 : n + 1; end
`ifdef ALU_MC_MUL_EN
      4'd13: begin r = ua * ub; e.lat = 17; end
`endif
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.c    = r[15:0];
    e.zero = (e.c == 16'h0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] code, input logic [15:0] ia, input logic [15:0] ib,
                       input bit expect_it);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!in_ready) begin
      a = 16'($urandom);
      b = 16'($urandom);
      alu_code = 4'($urandom);
      guard++;
      if (guard > 300) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    a = ia;
    b = ib;
    alu_code = code;
    if (expect_it) begin
      e = model(code, ia, ib);
      e.acc_cyc = cyc + 1;
      expq.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    alu_code = 4'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((expq.size() != 0 || out_valid) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 32'(expq.size()), 32'd0);
  endtask

  initial begin : monitor
    exp_t cur;
    bit   seen;
    int   stall;
    seen  = 1'b0;
    stall = 0;
    cur   = '{c: 16'h0, zero: 1'b0, ovf: 1'b0, err: 1'b0, lat: 0, acc_cyc: 0};
    forever begin
      @(negedge clk);
      if (out_valid) begin
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (!seen) begin
          if (expq.size() == 0) begin
            chk("unexpected_result", 32'(out_valid), 32'd0);
          end else begin
            cur = expq.pop_front();
            chk("c", 32'(c), 32'(cur.c));
            chk("zero", 32'(zero), 32'(cur.zero));
            chk("ovf", 32'(ovf), 32'(cur.ovf));
            chk("err", 32'(err), 32'(cur.err));
            chk("latency", 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
          end
          seen = 1'b1;
          stall = stall_req;
          stall_req = 0;
        end else begin
          chk("c_stable", 32'(c), 32'(cur.c));
          chk("zero_stable", 32'(zero), 32'(cur.zero));
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        seen = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : stimulus
    logic [3:0]  code;
    logic [15:0] ra, rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    issue(4'd0, 16'h7FFF, 16'h0001, 1'b1);
    issue(4'd1, 16'd5, 16'd5, 1'b1);
    issue(4'd7, 16'h8002, 16'h0000, 1'b1);
    issue(4'd12, 16'h8000, 16'd15, 1'b1);
    issue(4'd11, 16'h1234, 16'h0000, 1'b1);
    issue(4'd11, 16'h0001, 16'h000F, 1'b1);
    issue(4'd13, 16'd300, 16'd300, 1'b1);
    issue(4'd14, 16'h1111, 16'h2222, 1'b1);
    issue(4'd15, 16'hFFFF, 16'hFFFF, 1'b1);
    issue(4'd1, 16'h8000, 16'h0001, 1'b1);
    drain();

    // Stall the consumer while inputs keep toggling; the held result must not move.
    stall_req = 6;
    issue(4'd8, 16'h0000, 16'h00AB, 1'b1);
    drain();

    // Reset during a long operation must abort it with no result.
`ifdef ALU_MC_MUL_EN
    issue(4'd13, 16'd300, 16'd300, 1'b0);
`else
    issue(4'd12, 16'h8000, 16'd15, 1'b0);
`endif
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_c", 32'(c), 32'd0);
    chk("abort_zero", 32'(zero), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (25) @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      code = 4'($urandom_range(0, 15));
      ra   = 16'($urandom);
      rb   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h0000;
      issue(code, ra, rb, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, operand/result width (>=4, power of 2).
REQ-002 The block SHALL have parameter SHAMT_W, default $clog2(WORD_SIZE), width of shift amount taken from b.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  request present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have ports a and b  input  WORD_SIZE  operands.
REQ-008 The block SHALL have port alu_code  input  4  operation select.
REQ-009 The block SHALL have port out_valid  output  1  result present.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-011 The block SHALL have port c  output  WORD_SIZE  result.
REQ-012 The block SHALL have ports zero, ovf, err  output  1 each  result==0; signed overflow (ADD/SUB only); illegal code.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 Accept SHALL occur on an edge with in_valid&in_ready; a, b, alu_code are captured at that edge and later input changes have no effect.
REQ-015 Codes 0-10 (ADD, SUB, AND, ORR, NOT, TCP, SHL1, SHR1 arithmetic, LHI=b<<8, PASS_A, PASS_B) SHALL go IDLE->DONE at the accept edge: out_valid on the next cycle, latency 1.
REQ-016 Code 11 SHLN and code 12 SHRN (arithmetic) SHALL shift a by n=b[SHAMT_W-1:0], one bit per cycle in EXEC; n=0 goes directly to DONE with c=a.
REQ-017 A SHLN/SHRN with n>0 SHALL hold out_valid after n+1 edges counted from the accept edge.
REQ-018 Code 13 MUL SHALL be a shift-add over WORD_SIZE cycles in EXEC; c=low WORD_SIZE bits of a*b (unsigned); latency WORD_SIZE+1.
REQ-019 Arithmetic SHALL be modulo 2^WORD_SIZE; ovf=1 iff ADD/SUB operand signs imply a sign flip, else 0.
REQ-020 Codes 14-15, and 13 when the multiply is compiled out, SHALL give c=0, err=1, latency 1; err=0 for every legal code.
REQ-021 DONE SHALL hold c/zero/ovf/err stable until an edge with out_ready=1, then go to IDLE; no new accept can occur on that same edge.
REQ-022 out_ready asserted before DONE SHALL have no effect.
REQ-023 The EXEC counter SHALL be SHAMT_W+1 bits wide, so that n=WORD_SIZE-1 and MUL never wrap early.

Reset
REQ-024 On a reset edge the FSM SHALL go to IDLE and c, zero, ovf, err, out_valid and the counter SHALL be 0; zero resets to 0, not 1.
REQ-025 Reset SHALL abort any EXEC/DONE operation without producing a result; reset overrides a simultaneous accept.
REQ-026 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-027 Macro ALU_MC_MUL_EN defined: the MUL datapath and code 13 SHALL be present.
REQ-028 Macro ALU_MC_MUL_EN undefined: no multiplier logic SHALL be present, and code 13 behaves as illegal (REQ-020).

Structure
REQ-029 Shared package SHALL hold the 4-bit ALU code constants (FUNC_ADD..FUNC_MUL) and the FSM state encoding.
REQ-030 Sub-module alu_mc_shiftmul SHALL contain the iterative shift/multiply datapath with its counter; alu_mc holds the FSM, single-cycle ops and flags.

Verification
REQ-031 ADD a=16'h7FFF, b=1, out_ready=1 -> out_valid 1 cycle after accept, c=16'h8000, ovf=1, zero=0.
REQ-032 SUB a=5, b=5 -> c=0, zero=1, ovf=0; SHR1 a=16'h8002 -> c=16'hC001.
REQ-033 SHRN a=16'h8000, b=15 -> out_valid after 16 edges, c=16'hFFFF; SHLN b=0 -> latency 1, c=a.
REQ-034 MUL a=300, b=300 with ALU_MC_MUL_EN -> latency 17, c=16'h5F90; without the macro -> latency 1, c=0, err=1.
REQ-035 out_ready held 0 for 5 cycles in DONE while a/b toggle -> c stable and in_ready=0; reset asserted mid-MUL -> next cycle IDLE, all outputs 0, in_ready=1.
